// File: rtl/z_core_pkg.sv
// Constants shared across the z_core front end: AXI encodings and the
// prefetch FSM state codes.
package z_core_pkg;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/z_core_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, a same-cycle flush and a
// free-entry count for callers that reserve space ahead of writing.
module z_core_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [PTR_W-1:0] free
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  // Same index with opposite wrap bits means the writer has lapped the reader.
  assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                 (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign count = wr_ptr - rd_ptr;
  assign free  = PTR_W'(DEPTH) - count;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign head_data = mem[rd_ptr[IDX_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define
  // which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/z_core_i_prefetch_queue.sv
// Instruction prefetcher: issues aligned AXI INCR bursts from fetch_pc into
// a queue whose space is reserved before each burst, so m_rready never stalls.
module z_core_i_prefetch_queue
  import z_core_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,

  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,

  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,

  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_err
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int SUM_W   = CNT_W + 1;
  localparam int BEAT_W  = $clog2(BURST_LEN) + 1;
  localparam int ENTRY_W = 32 + ADDR_W + 1;

  // Beats left before the next BURST_LEN-word boundary.
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [ADDR_W-1:0] pc);
    logic [ADDR_W-1:0] word_off;
    word_off = (pc >> 2) & ADDR_W'(BURST_LEN - 1);
    return BEAT_W'(BURST_LEN) - BEAT_W'(word_off);
  endfunction

  logic [2:0]         state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic               pc_valid;
  logic [ADDR_W-1:0]  beat_pc;
  logic [BEAT_W-1:0]  cur_beats;
  logic [CNT_W-1:0]   reserved;
  logic               err_seen;
  logic               drain_pending;

  logic [BEAT_W-1:0]  next_beats;
  logic               room;
  logic               beat_err;

  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CNT_W-1:0]   fifo_free;

  assign next_beats = burst_beats(fetch_pc);
  assign room       = SUM_W'(fifo_free) >= (SUM_W'(reserved) + SUM_W'(next_beats));
  assign beat_err   = resp_is_err(m_rresp);

  assign m_arvalid = (state == ST_ADDR);
  assign m_rready  = (state == ST_DATA) || (state == ST_DRAIN);
  assign m_arsize  = SIZE_4B;
  assign m_arburst = BURST_INCR;

  // A redirect flushes the queue this cycle, so the beat and pop it meets are dropped.
  assign fifo_push  = (state == ST_DATA) && m_rvalid && !redirect_valid && !fifo_full;
  assign fifo_pop   = instr_valid && instr_ready && !redirect_valid;
  assign fifo_wdata = {m_rdata, beat_pc, beat_err};

  z_core_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .free      (fifo_free)
  );

  assign instr_valid = !fifo_empty;
  assign instr_data  = fifo_head[ENTRY_W-1 -: 32];
  assign instr_pc    = fifo_head[ADDR_W:1];
  assign instr_err   = !fifo_empty && fifo_head[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      fetch_pc      <= '0;
      pc_valid      <= 1'b0;
      beat_pc       <= '0;
      cur_beats     <= '0;
      reserved      <= '0;
      err_seen      <= 1'b0;
      drain_pending <= 1'b0;
      m_araddr      <= '0;
      m_arlen       <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        pc_valid <= 1'b1;
        err_seen <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          // Never launch in the redirect cycle: fetch_pc is still the old stream.
          if (!redirect_valid && pc_valid && room) begin
            state     <= ST_ADDR;
            m_araddr  <= fetch_pc;
            m_arlen   <= 8'(next_beats) - 8'd1;
            cur_beats <= next_beats;
            beat_pc   <= fetch_pc;
            reserved  <= CNT_W'(next_beats);
          end
        end

        ST_ADDR: begin
          // The address phase cannot be withdrawn; remember to discard its data.
          if (redirect_valid) begin
            drain_pending <= 1'b1;
            reserved      <= '0;
          end
          if (m_arready) begin
            drain_pending <= 1'b0;
            if (redirect_valid || drain_pending) begin
              state <= ST_DRAIN;
            end else begin
              state    <= ST_DATA;
              fetch_pc <= fetch_pc + (ADDR_W'(cur_beats) << 2);
            end
          end
        end

        ST_DATA: begin
          if (redirect_valid) begin
            reserved <= '0;
            state    <= (m_rvalid && m_rlast) ? ST_IDLE : ST_DRAIN;
          end else if (m_rvalid) begin
            beat_pc  <= beat_pc + ADDR_W'(4);
            reserved <= reserved - CNT_W'(1);
            if (beat_err) err_seen <= 1'b1;
            if (m_rlast) begin
              reserved <= '0;
              err_seen <= 1'b0;
              state    <= (err_seen || beat_err) ? ST_HALT : ST_IDLE;
            end
          end
        end

        ST_DRAIN: begin
          if (m_rvalid && m_rlast) state <= ST_IDLE;
        end

        ST_HALT: begin
          if (redirect_valid) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z_core_i_prefetch_queue.sv
// Bench for the prefetch queue: a behavioural AXI slave, an in-order
// instruction-stream model checked every cycle, and directed scenarios.
module tb_z_core_i_prefetch_queue;

  localparam int ADDR_W    = 32;
  localparam int DEPTH     = 8;
  localparam int BURST_LEN = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              m_arvalid;
  logic              m_arready = 1'b0;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_rvalid = 1'b0;
  logic              m_rready;
  logic [31:0]       m_rdata = '0;
  logic [1:0]        m_rresp = '0;
  logic              m_rlast = 1'b0;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [31:0]       instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_err;

  int tests_run    = 0;
  int tests_failed = 0;

  z_core_i_prefetch_queue #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .m_arvalid      (m_arvalid),
    .m_arready      (m_arready),
    .m_araddr       (m_araddr),
    .m_arlen        (m_arlen),
    .m_arsize       (m_arsize),
    .m_arburst      (m_arburst),
    .m_rvalid       (m_rvalid),
    .m_rready       (m_rready),
    .m_rdata        (m_rdata),
    .m_rresp        (m_rresp),
    .m_rlast        (m_rlast),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_err      (instr_err)
  );

  always #5 clk = ~clk;

  // Memory image: the word at byte address a.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Beats minus one from a to the next BURST_LEN-word boundary.
  function automatic int exp_len(input logic [31:0] a);
    return BURST_LEN - 1 - int'((a >> 2) % BURST_LEN);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- AXI slave (drives at the falling edge) ----------------
  int          ar_wait = 0;
  int          s_ar_cnt = 0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = '0;
  bit          s_busy = 1'b0;
  bit          s_ar_hs = 1'b0;
  bit          s_r_hs = 1'b0;
  logic [31:0] s_addr = '0;
  logic [31:0] s_start = '0;
  int          s_len = 0;
  int          s_idx = 0;
  logic [31:0] cap_addr = '0;
  int          cap_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      s_busy = 1'b0; s_ar_hs = 1'b0; s_r_hs = 1'b0; s_ar_cnt = 0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; m_rdata = '0;
    end else begin
      if (s_r_hs) begin
        if (s_idx == s_len) s_busy = 1'b0;
        else begin s_idx++; s_addr += 32'd4; end
      end
      if (s_ar_hs) begin
        s_busy = 1'b1; s_addr = cap_addr; s_start = cap_addr; s_len = cap_len; s_idx = 0;
      end
      if (m_arvalid && !s_busy) begin
        m_arready = (s_ar_cnt >= ar_wait);
        s_ar_cnt++;
      end else begin
        m_arready = 1'b0;
        s_ar_cnt  = 0;
      end
      s_ar_hs = m_arvalid && m_arready;
      if (s_ar_hs) begin
        cap_addr = m_araddr; cap_len = int'(m_arlen); s_ar_cnt = 0;
      end
      if (s_busy) begin
        m_rvalid = 1'b1;
        m_rdata  = mem_word(s_addr);
        m_rresp  = (err_en && s_addr == err_addr) ? 2'b10 : 2'b00;
        m_rlast  = (s_idx == s_len);
      end else begin
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
      end
      s_r_hs = m_rvalid && m_rready;
    end
  end

  // ---------------- stream model and per-cycle compare ----------------
  logic [31:0] exp_pc = '0;
  bit          exp_pc_valid = 1'b0;
  bit          prev_redirect = 1'b0;
  bit          prev_ar_pend = 1'b0;
  logic [31:0] prev_araddr = '0;
  logic [7:0]  prev_arlen = '0;
  logic [31:0] ar_addr_log[$];
  int          ar_len_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_data_log[$];
  bit          pop_err_log[$];

  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_pc_valid  = 1'b0;
      prev_redirect = 1'b0;
      prev_ar_pend  = 1'b0;
    end else begin
      if (prev_redirect) check("empty_after_redirect", instr_valid, 1'b0);
      if (prev_ar_pend)
        check("ar_held_stable", {m_arvalid, m_araddr, m_arlen}, {1'b1, prev_araddr, prev_arlen});
      if (m_arvalid && m_arready) begin
        check("arlen_boundary_rule", m_arlen, exp_len(m_araddr));
        ar_addr_log.push_back(m_araddr);
        ar_len_log.push_back(int'(m_arlen));
      end
      prev_ar_pend = m_arvalid && !m_arready;
      prev_araddr  = m_araddr;
      prev_arlen   = m_arlen;

      if (redirect_valid) begin
        exp_pc       = redirect_pc;
        exp_pc_valid = 1'b1;
      end else if (instr_valid && instr_ready) begin
        if (!exp_pc_valid) begin
          check("pop_before_redirect", instr_valid, 1'b0);
        end else begin
          check("pop_pc", instr_pc, exp_pc);
          check("pop_data", instr_data, mem_word(exp_pc));
          check("pop_err", instr_err, err_en && (exp_pc == err_addr));
        end
        pop_pc_log.push_back(instr_pc);
        pop_data_log.push_back(instr_data);
        pop_err_log.push_back(instr_err);
        exp_pc += 32'd4;
      end
      prev_redirect = redirect_valid;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  task automatic clear_logs();
    ar_addr_log.delete(); ar_len_log.delete();
    pop_pc_log.delete(); pop_data_log.delete(); pop_err_log.delete();
  endtask

  task automatic quiesce();
    instr_ready = 1'b0;
    tick(40);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, m_arvalid, 1'b0);
    check({tag, "_rready"}, m_rready, 1'b0);
    check({tag, "_instr_valid"}, instr_valid, 1'b0);
    check({tag, "_araddr"}, m_araddr, 32'h0);
    check({tag, "_arlen"}, m_arlen, 8'h0);
    check({tag, "_instr_err"}, instr_err, 1'b0);
  endtask

  initial begin
    bit found;
    tick(2);
    check_reset_outputs("reset");
    check("arsize_const", m_arsize, 3'b010);
    check("arburst_const", m_arburst, 2'b01);
    rst = 1'b0;
    tick(5);
    check("no_ar_before_redirect", ar_addr_log.size(), 0);

    // Aligned redirect, streaming consumer.
    instr_ready = 1'b1;
    do_redirect(32'h100);
    tick(30);
    check("t1_ar0_addr", ar_addr_log[0], 32'h100);
    check("t1_ar0_len", ar_len_log[0], 3);
    check("t1_pop0_pc", pop_pc_log[0], 32'h100);
    check("t1_pop3_pc", pop_pc_log[3], 32'h10C);
    check("t1_pop0_data", pop_data_log[0], 32'h0100_FEFF);

    // Unaligned redirect: short first burst, then a full one.
    quiesce();
    clear_logs();
    do_redirect(32'h108);
    tick(30);
    check("t2_ar_count", ar_addr_log.size(), 2);
    check("t2_ar0_addr", ar_addr_log[0], 32'h108);
    check("t2_ar0_len", ar_len_log[0], 1);
    check("t2_ar1_addr", ar_addr_log[1], 32'h110);
    check("t2_ar1_len", ar_len_log[1], 3);

    // Stalled consumer: two bursts fill the queue; AR waits for 4 free.
    clear_logs();
    do_redirect(32'h100);
    tick(30);
    check("t3_ar_count_full", ar_addr_log.size(), 2);
    check("t3_ar1_addr", ar_addr_log[1], 32'h110);
    check("t3_valid_full", instr_valid, 1'b1);
    instr_ready = 1'b1; tick(1); instr_ready = 1'b0;
    tick(20);
    check("t3_ar_count_1free", ar_addr_log.size(), 2);
    instr_ready = 1'b1; tick(2); instr_ready = 1'b0;
    tick(20);
    check("t3_ar_count_3free", ar_addr_log.size(), 2);
    instr_ready = 1'b1; tick(1); instr_ready = 1'b0;
    tick(20);
    check("t3_ar_count_4free", ar_addr_log.size(), 3);
    check("t3_ar2_addr", ar_addr_log[2], 32'h120);
    check("t3_pop3_pc", pop_pc_log[3], 32'h10C);

    // Redirect on the third beat of the burst at 0x100.
    quiesce();
    clear_logs();
    ar_wait = 1;
    instr_ready = 1'b1;
    do_redirect(32'h100);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (s_busy && s_start == 32'h100 && s_idx == 2 && m_rvalid) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    check("t4_reached_beat3", found, 1'b1);
    clear_logs();
    do_redirect(32'h200);
    check("t4_empty_next_cycle", instr_valid, 1'b0);
    tick(30);
    check("t4_ar0_addr", ar_addr_log[0], 32'h200);
    check("t4_ar0_len", ar_len_log[0], 3);
    check("t4_pop0_pc", pop_pc_log[0], 32'h200);
    ar_wait = 0;

    // Error on the second beat halts fetching until the next redirect.
    quiesce();
    clear_logs();
    err_addr = 32'h304;
    err_en   = 1'b1;
    instr_ready = 1'b1;
    do_redirect(32'h300);
    tick(40);
    check("t5_ar_count_halted", ar_addr_log.size(), 1);
    check("t5_pop_count", pop_pc_log.size(), 4);
    check("t5_beat1_ok", pop_err_log[0], 1'b0);
    check("t5_beat2_err", pop_err_log[1], 1'b1);
    check("t5_queue_empty", instr_valid, 1'b0);
    clear_logs();
    err_en = 1'b0;
    do_redirect(32'h400);
    tick(20);
    check("t5_resume_ar_addr", ar_addr_log[0], 32'h400);
    check("t5_resume_pop_pc", pop_pc_log[0], 32'h400);

    // Reset in the middle of a data phase.
    quiesce();
    clear_logs();
    instr_ready = 1'b1;
    do_redirect(32'h500);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_rready) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    check("t6_reached_data", found, 1'b1);
    rst = 1'b1;
    clear_logs();
    tick(1);
    check_reset_outputs("t6_midburst");
    rst = 1'b0;
    tick(10);
    check("t6_no_ar_after_reset", ar_addr_log.size(), 0);
    check("t6_no_pop_after_reset", pop_pc_log.size(), 0);
    do_redirect(32'h600);
    tick(20);
    check("t6_resume_ar_addr", ar_addr_log[0], 32'h600);
    check("t6_resume_pop_pc", pop_pc_log[0], 32'h600);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1);
  end

endmodule
